cpu_ram_we_swiz_burst: RTL and testbench

- Burst-capable, multi-lane successor to the single-lane CPU RAM write-enable swizzle qualifier in the LU example.
- Accepts one CPU burst command (start row/col coordinate, beat count) and walks the swizzled matrix memory one lane-group per beat.
- Each beat emits a lane-group address plus a per-lane write-enable vector, masked against runtime matrix bounds.
- Sits between the CPU write-command interface and the LANES banked RAMs.

---
 rtl/cpu_ram_we_swiz_burst.sv | 153 +++++++++++++++
 tb/tb_cpu_ram_we_swiz_burst.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cpu_ram_we_swiz_burst.sv
// Burst walker over a lane-swizzled matrix RAM: one lane-group address plus bounded per-lane write enables per beat.
// Optional CPU_RAM_WE_SWIZ_MASKCNT_EN adds o_mask_cnt, a saturating count of mask-suppressed lanes.
module cpu_ram_we_swiz_burst #(
  parameter int COORD_BITS = 4,
  parameter int SWIZ_BITS  = 2,
  parameter int LEN_BITS   = 8,
  localparam int LANES     = 2 ** SWIZ_BITS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2*COORD_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]     cmd_len,
  input  logic [COORD_BITS:0]     cfg_ncols,
  input  logic [COORD_BITS:0]     cfg_nrows,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [2*COORD_BITS-1:0] o_addr,
  output logic [LANES-1:0]        o_we,
`ifdef CPU_RAM_WE_SWIZ_MASKCNT_EN
  output logic [15:0]             o_mask_cnt,
`endif
  output logic                    o_last
);

  localparam logic [COORD_BITS-1:0] LOW_MASK = COORD_BITS'(LANES - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [COORD_BITS-1:0] row_p1, col_p1;
  logic [LEN_BITS-1:0]   rem_p1;
  logic [COORD_BITS:0]   ncols_p1, nrows_p1;
  logic [LANES-1:0]      we_p1;
  logic                  last_p1, vld_p1;

  logic accept, advance, done, hs;

  function automatic logic [LANES-1:0] lane_mask(
    input logic [COORD_BITS-1:0] row,
    input logic [COORD_BITS-1:0] col,
    input logic [COORD_BITS:0]   nrows,
    input logic [COORD_BITS:0]   ncols
  );
    logic [LANES-1:0] m;
    m = '0;
    for (int l = 0; l < LANES; l++) begin
      m[l] = ({1'b0, row} < nrows) &&
             (({1'b0, col} + (COORD_BITS+1)'(l)) < ncols);
    end
    return m;
  endfunction

  // Saturating add of suppressed-lane count into a 16-bit accumulator
  function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [LANES-1:0] we);
    logic [16:0] sum;
    sum = {1'b0, acc} + 17'(LANES) - 17'($countones(we));
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [COORD_BITS-1:0] cmd_row, cmd_col;
  logic [COORD_BITS:0]   col_sum;
  logic [COORD_BITS-1:0] next_row, next_col;

  assign cmd_row  = cmd_addr[2*COORD_BITS-1:COORD_BITS];
  assign cmd_col  = cmd_addr[COORD_BITS-1:0] & ~LOW_MASK;
  assign col_sum  = {1'b0, col_p1} + (COORD_BITS+1)'(LANES);
  assign next_col = col_sum[COORD_BITS] ? '0 : col_sum[COORD_BITS-1:0];
  assign next_row = col_sum[COORD_BITS] ? row_p1 + 1'b1 : row_p1;

  assign cmd_ready = (state_q == IDLE) && reset_n;
  assign hs        = vld_p1 && o_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          if (last_p1) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered beat presented to the RAM banks; holds while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_p1   <= '0;
      col_p1   <= '0;
      rem_p1   <= '0;
      ncols_p1 <= '0;
      nrows_p1 <= '0;
      we_p1    <= '0;
      last_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (accept) begin
      row_p1   <= cmd_row;
      col_p1   <= cmd_col;
      rem_p1   <= cmd_len;
      ncols_p1 <= cfg_ncols;
      nrows_p1 <= cfg_nrows;
      we_p1    <= lane_mask(cmd_row, cmd_col, cfg_nrows, cfg_ncols);
      last_p1  <= (cmd_len == '0);
      vld_p1   <= 1'b1;
    end else if (advance) begin
      row_p1   <= next_row;
      col_p1   <= next_col;
      rem_p1   <= rem_p1 - 1'b1;
      we_p1    <= lane_mask(next_row, next_col, nrows_p1, ncols_p1);
      last_p1  <= (rem_p1 == LEN_BITS'(1));
    end else if (done) begin
      we_p1    <= '0;
      last_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end
  end

`ifdef CPU_RAM_WE_SWIZ_MASKCNT_EN
  logic [15:0] mask_cnt_p2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  mask_cnt_p2 <= '0;
    else if (hs)   mask_cnt_p2 <= sat_add16(mask_cnt_p2, we_p1);
  end
  assign o_mask_cnt = mask_cnt_p2;
`endif

  assign o_valid = vld_p1;
  assign o_addr  = {row_p1, col_p1};
  assign o_we    = we_p1;
  assign o_last  = last_p1;

endmodule

// File: tb/tb_cpu_ram_we_swiz_burst.sv
// Directed + randomized bench for cpu_ram_we_swiz_burst against a linear lane-group index model.
module tb_cpu_ram_we_swiz_burst;
  localparam int LANES  = 4;
  localparam int GROUPS = 16 / LANES;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [4:0] cfg_ncols = 5'd16;
  logic [4:0] cfg_nrows = 5'd16;
  logic       o_valid;
  logic       o_ready = 1'b0;
  logic [7:0] o_addr;
  logic [3:0] o_we;
  logic       o_last;
`ifdef CPU_RAM_WE_SWIZ_MASKCNT_EN
  logic [15:0] o_mask_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cnt_model = 0;

  cpu_ram_we_swiz_burst #(.COORD_BITS(4), .SWIZ_BITS(2), .LEN_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cfg_ncols(cfg_ncols), .cfg_nrows(cfg_nrows),
    .o_valid(o_valid), .o_ready(o_ready), .o_addr(o_addr), .o_we(o_we),
`ifdef CPU_RAM_WE_SWIZ_MASKCNT_EN
    .o_mask_cnt(o_mask_cnt),
`endif
    .o_last(o_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_we(input int r, input int c, input int nr, input int nc);
    logic [3:0] m;
    for (int l = 0; l < LANES; l++) m[l] = (r < nr) && (c + l < nc);
    return m;
  endfunction

  // Issues one command and follows it beat by beat; entered and left just after a falling edge.
  task automatic run_burst(input int row, input int col, input int len, input int nc, input int nr,
                           input int stall_at, input bit rnd_stall, input bit expect_no_wait);
    int waited, k, cyc, stall_left, g, r, c;
    bit stalled;
    logic [3:0] we;
    cmd_addr  = 8'(row * 16 + col);
    cmd_len   = 8'(len);
    cfg_ncols = 5'(nc);
    cfg_nrows = 5'(nr);
    cmd_valid = 1'b1;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); @(negedge clk); waited++;
    end
    check("cmd_ready_wait", 32'(waited < 50), 32'd1);
    if (expect_no_wait) check("b2b_gap", waited, 0);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    cfg_ncols = 5'($urandom_range(1, 16));
    cfg_nrows = 5'($urandom_range(1, 16));
    k = 0; cyc = 0; stall_left = 0; stalled = 1'b0;
    while (k <= len && cyc < 2000) begin
      g  = row * GROUPS + col / LANES + k;
      r  = (g / GROUPS) % 16;
      c  = (g % GROUPS) * LANES;
      we = exp_we(r, c, nr, nc);
      check("o_valid", 32'(o_valid), 32'd1);
      check("o_addr", 32'(o_addr), r * 16 + c);
      check("o_we", 32'(o_we), 32'(we));
      check("o_last", 32'(o_last), 32'(k == len));
      check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (k == stall_at && !stalled) begin
        stall_left = 3;
        stalled = 1'b1;
      end
      if (stall_left > 0) begin
        o_ready = 1'b0;
        stall_left--;
      end else if (rnd_stall) begin
        o_ready = 1'($urandom_range(0, 1));
      end else begin
        o_ready = 1'b1;
      end
      if (o_ready) begin
        cnt_model = cnt_model + LANES - $countones(we);
        if (cnt_model > 65535) cnt_model = 65535;
        k++;
      end
      @(posedge clk); @(negedge clk); cyc++;
    end
    check("burst_bounded", 32'(cyc < 2000), 32'd1);
    o_ready = 1'b0;
    check("o_valid_after", 32'(o_valid), 32'd0);
    check("cmd_ready_after", 32'(cmd_ready), 32'd1);
`ifdef CPU_RAM_WE_SWIZ_MASKCNT_EN
    check("mask_cnt", 32'(o_mask_cnt), cnt_model);
`endif
  endtask

  initial begin
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_we", 32'(o_we), 32'd0);
    check("rst_o_addr", 32'(o_addr), 32'd0);
    check("rst_o_last", 32'(o_last), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("cmd_ready_post_rst", 32'(cmd_ready), 32'd1);

    // full-size burst, partial mask, wrap to next row, backpressure, low-bit masking
    run_burst(0, 0, 3, 16, 16, -1, 1'b0, 1'b0);
    run_burst(2, 4, 1, 6, 16, -1, 1'b0, 1'b1);
`ifdef CPU_RAM_WE_SWIZ_MASKCNT_EN
    check("mask_cnt_case2", 32'(o_mask_cnt), 32'd6);
`endif
    run_burst(3, 12, 1, 16, 4, -1, 1'b0, 1'b1);
    run_burst(1, 0, 5, 10, 16, 2, 1'b0, 1'b1);
    run_burst(5, 5, 0, 16, 16, -1, 1'b0, 1'b1);
    run_burst(7, 9, 2, 13, 8, -1, 1'b0, 1'b1);
    run_burst(15, 8, 3, 16, 16, -1, 1'b0, 1'b1);

    // asynchronous reset while beat 2 of an 8-beat burst is on the bus
    @(negedge clk);
    cmd_addr = 8'h00; cmd_len = 8'd7; cfg_ncols = 5'd16; cfg_nrows = 5'd16; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; o_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("mid_o_valid", 32'(o_valid), 32'd1);
    check("mid_o_addr", 32'(o_addr), 32'h08);
    #2 reset_n = 1'b0;
    #1;
    check("arst_o_valid", 32'(o_valid), 32'd0);
    check("arst_o_we", 32'(o_we), 32'd0);
    check("arst_o_addr", 32'(o_addr), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    cnt_model = 0;
`ifdef CPU_RAM_WE_SWIZ_MASKCNT_EN
    check("arst_mask_cnt", 32'(o_mask_cnt), 32'd0);
`endif
    o_ready = 1'b0;
    @(negedge clk);
    check("arst_hold_valid", 32'(o_valid), 32'd0);
    reset_n = 1'b1;
    #1 check("arst_release_ready", 32'(cmd_ready), 32'd1);
    run_burst(4, 4, 2, 16, 16, -1, 1'b0, 1'b1);

    for (int i = 0; i < 25; i++) begin
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 12)),
                int'($urandom_range(1, 16)), int'($urandom_range(1, 16)), -1, 1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
